// File: rtl/serial_slice_adder_pkg.sv
// Shared constants and types for serial_slice_adder.
//   SLICE_W : bits processed per cycle by the slice adder
//   state_e : controller states
package serial_slice_adder_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_slice_adder_add4_slice.sv
// Combinational SLICE_W-bit ripple-carry adder (one slice of the serial adder).
//   a_i, b_i : slice operands
//   cin_i    : carry into bit 0
//   sum_o    : slice sum
//   cout_o   : carry out of the top bit
module add4_slice
    import serial_slice_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    logic c;

    always_comb begin
        c     = cin_i;
        sum_o = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle WIDTH-bit adder: one SLICE_W-bit slice per clock, carry
// registered between slices. valid/ready handshake on input and output.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake
//   sum, cout           : registered result, cout:sum = a+b+cin
//   ovf                 : signed overflow, present only with OVERFLOW_FLAG_EN
// Optional feature macro: OVERFLOW_FLAG_EN
module serial_slice_adder
    import serial_slice_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
   ,output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
            $error("serial_slice_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef OVERFLOW_FLAG_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic [SLICE_W-1:0] s4;
    logic               c4;
    // New slice enters at the top; the lowest slice falls off the bottom.
    // Written as a concat+slice so it also works when WIDTH == SLICE_W.
    logic [WIDTH+SLICE_W-1:0] sum_cat;
    logic [WIDTH-1:0]         sum_sh_nxt;

    add4_slice u_slice (
        .a_i    (a_sh_q[SLICE_W-1:0]),
        .b_i    (b_sh_q[SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (s4),
        .cout_o (c4)
    );

    assign sum_cat    = {s4, sum_sh_q};
    assign sum_sh_nxt = sum_cat[WIDTH+SLICE_W-1:SLICE_W];

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
`ifdef OVERFLOW_FLAG_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                // in_ready is low out of reset and rises on the first edge here
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    carry_d    = cin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
`ifdef OVERFLOW_FLAG_EN
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> SLICE_W;
                b_sh_d   = b_sh_q >> SLICE_W;
                sum_sh_d = sum_sh_nxt;
                carry_d  = c4;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d       = sum_sh_nxt;
                    cout_d      = c4;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d       = (a_msb_q == b_msb_q) && (sum_sh_nxt[WIDTH-1] != a_msb_q);
`endif
                end
            end
            DONE: begin
                // No accept on the handshake edge; in_ready is only seen next cycle
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
`ifdef OVERFLOW_FLAG_EN
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule
